// File: rtl/memwb_stage.sv
`default_nettype none
// =============================================================================
// memwb_stage : MEM/WB pipeline register with a two-entry skid buffer and
//               writeback source selection.                      Rev 1.0
// =============================================================================
module memwb_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int SEL_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SEL_W-1:0]  in_mem_to_reg,
  input  logic              in_reg_write,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [REG_AW-1:0] in_dest,
  input  logic [DATA_W-1:0] in_link,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_dest,
  output logic [DATA_W-1:0] wb_data,
  output logic [1:0]        level
);

  localparam logic [1:0] c_sel_alu  = 2'd0;
  localparam logic [1:0] c_sel_mem  = 2'd1;
  localparam logic [1:0] c_sel_link = 2'd2;

  logic              r_main_valid, r_skid_valid;
  logic [SEL_W-1:0]  r_main_sel,   r_skid_sel;
  logic              r_main_rw,    r_skid_rw;
  logic [DATA_W-1:0] r_main_mem,   r_skid_mem;
  logic [DATA_W-1:0] r_main_alu,   r_skid_alu;
  logic [REG_AW-1:0] r_main_dest,  r_skid_dest;
  logic [DATA_W-1:0] r_main_link,  r_skid_link;

  logic w_accept, w_xfer, w_load_main, w_move, w_load_skid;

  assign in_ready    = rst & ~r_skid_valid;
  assign w_accept    = in_valid & in_ready;
  assign w_xfer      = r_main_valid & out_ready;
  // Main only takes fresh input when nothing older is waiting in skid.
  assign w_load_main = w_accept & (~r_main_valid | w_xfer) & ~r_skid_valid;
  assign w_move      = w_xfer & r_skid_valid;
  assign w_load_skid = w_accept & ~w_load_main;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main_sel   <= '0;
      r_main_rw    <= 1'b0;
      r_main_mem   <= '0;
      r_main_alu   <= '0;
      r_main_dest  <= '0;
      r_main_link  <= '0;
      r_skid_sel   <= '0;
      r_skid_rw    <= 1'b0;
      r_skid_mem   <= '0;
      r_skid_alu   <= '0;
      r_skid_dest  <= '0;
      r_skid_link  <= '0;
    end else begin
      if (flush) begin
        r_main_valid <= 1'b0;
        r_skid_valid <= 1'b0;
      end else begin
        r_main_valid <= w_load_main | w_move | (r_main_valid & ~w_xfer);
        r_skid_valid <= w_load_skid | (r_skid_valid & ~w_move);
      end

      if (!flush && w_move) begin
        r_main_sel  <= r_skid_sel;
        r_main_rw   <= r_skid_rw;
        r_main_mem  <= r_skid_mem;
        r_main_alu  <= r_skid_alu;
        r_main_dest <= r_skid_dest;
        r_main_link <= r_skid_link;
      end else if (!flush && w_load_main) begin
        r_main_sel  <= in_mem_to_reg;
        r_main_rw   <= in_reg_write;
        r_main_mem  <= in_mem_data;
        r_main_alu  <= in_alu_result;
        r_main_dest <= in_dest;
        r_main_link <= in_link;
      end

      if (!flush && w_load_skid) begin
        r_skid_sel  <= in_mem_to_reg;
        r_skid_rw   <= in_reg_write;
        r_skid_mem  <= in_mem_data;
        r_skid_alu  <= in_alu_result;
        r_skid_dest <= in_dest;
        r_skid_link <= in_link;
      end
    end
  end

  always_comb begin
    wb_data = '0;
    case (r_main_sel)
      c_sel_alu:  wb_data = r_main_alu;
      c_sel_mem:  wb_data = r_main_mem;
      c_sel_link: wb_data = r_main_link;
      default:    wb_data = '0;
    endcase
  end

  assign out_valid = r_main_valid;
  assign wb_dest   = r_main_dest;
  // Register 0 is hardwired, so its writes never reach the register file.
  assign wb_en     = r_main_valid & out_ready & r_main_rw & (r_main_dest != '0);
  assign level     = {1'b0, r_main_valid} + {1'b0, r_skid_valid};

endmodule
`default_nettype wire
